// File: rtl/fifo_rd_fwft_if.sv
// Read-side FIFO adapter bus: pop/data port toward the FIFO,
// valid/ready stream toward the consumer.
interface fifo_rd_fwft_if #(
  parameter int DATA_W = 8
);
  logic              fifo_empty;
  logic [DATA_W-1:0] fifo_rdata;
  logic              fifo_rd_en;
  logic              m_valid;
  logic [DATA_W-1:0] m_data;
  logic              m_ready;
  logic [1:0]        m_level;

  modport master (
    input  fifo_empty,
    input  fifo_rdata,
    input  m_ready,
    output fifo_rd_en,
    output m_valid,
    output m_data,
    output m_level
  );

  modport slave (
    output fifo_empty,
    output fifo_rdata,
    output m_ready,
    input  fifo_rd_en,
    input  m_valid,
    input  m_data,
    input  m_level
  );
endinterface

// File: rtl/fifo_rd_fwft.sv
// First-word-fall-through read adapter: turns one-cycle-latency
// FIFO pops into a valid/ready stream through a 2-entry skid buffer.
module fifo_rd_fwft #(
  parameter int DATA_W = 8
) (
  input logic            rd_clk,
  input logic            rd_reset,
  fifo_rd_fwft_if.master bus
);
  logic [1:0]        occ;
  logic              inflight;
  logic [DATA_W-1:0] head;
  logic [DATA_W-1:0] tail;

  logic       deq;
  logic [2:0] credit;
  logic       rd_en;
  logic       to_head;

  assign deq = (occ != 2'd0) && bus.m_ready;

  // occ + inflight never exceeds 2, so this cannot wrap
  assign credit = 3'd2 - {1'b0, occ} - {2'b0, inflight}
                + {2'b0, deq};

  assign rd_en = !bus.fifo_empty && (credit != 3'd0)
               && !rd_reset;

  assign to_head = (occ == 2'd0)
                 || ((occ == 2'd1) && deq);

  always_ff @(posedge rd_clk or posedge rd_reset) begin
    if (rd_reset) begin
      occ      <= 2'd0;
      inflight <= 1'b0;
      head     <= '0;
      tail     <= '0;
    end else begin
      inflight <= rd_en;
      occ      <= occ + {1'b0, inflight} - {1'b0, deq};
      if (deq && (occ == 2'd2)) begin
        head <= tail;
      end
      if (inflight) begin
        if (to_head) begin
          head <= bus.fifo_rdata;
        end else begin
          tail <= bus.fifo_rdata;
        end
      end
    end
  end

  assign bus.fifo_rd_en = rd_en;
  assign bus.m_valid    = (occ != 2'd0);
  assign bus.m_data     = head;
  assign bus.m_level    = occ;
endmodule
